// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side handshake and FIFO write-port signals shared by the write arbiter.
// master: arbiter side; slave: producers plus FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_din;
  logic [IDW-1:0]                grant_id;
  logic                          burst_active;

  modport master (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_din, grant_id, burst_active
  );

  modport slave (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_din, grant_id, burst_active
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
// Zero-latency valid/ready handshake; a full FIFO blocks every grant in the same cycle.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  fifo_wr_arbiter_if.master bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t         r_state;
  logic [IDW-1:0] r_owner;
  logic [IDW-1:0] r_last;
  logic [CW-1:0]  r_burst_cnt;

  state_t             w_state_nxt;
  logic [IDW-1:0]     w_owner_nxt;
  logic [IDW-1:0]     w_last_nxt;
  logic [CW-1:0]      w_cnt_nxt;
  logic [NUM_REQ-1:0] w_ready;
  logic [IDW-1:0]     w_gnt_id;
  logic               w_found;
  logic [IDW-1:0]     w_sel;
  logic [IDW-1:0]     w_cand;
  logic               w_wr_en;

  // Circular scan starting just after the last winner
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = IDW'((int'(r_last) + k) % NUM_REQ);
      if (!w_found && bus.req_valid[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_burst_cnt;
    w_ready     = '0;
    w_gnt_id    = '0;
    case (r_state)
      IDLE: begin
        if (w_found && !bus.fifo_full) begin
          w_ready[w_sel] = 1'b1;
          w_gnt_id       = w_sel;
          w_owner_nxt    = w_sel;
          w_last_nxt     = w_sel;
          w_cnt_nxt      = CW'(1);
          w_state_nxt    = (MAX_BURST > 1) ? BURST : IDLE;
        end
      end
      BURST: begin
        if (bus.req_valid[r_owner]) begin
          // A full FIFO stalls the owner without losing the burst
          if (!bus.fifo_full) begin
            w_ready[r_owner] = 1'b1;
            w_gnt_id         = r_owner;
            if (r_burst_cnt == CW'(MAX_BURST - 1)) begin
              w_state_nxt = IDLE;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_burst_cnt + CW'(1);
            end
          end
        end else begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_owner     <= '0;
      r_last      <= IDW'(NUM_REQ - 1);
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_last      <= w_last_nxt;
      r_burst_cnt <= w_cnt_nxt;
    end
  end

  assign w_wr_en          = rst_n && (|(bus.req_valid & w_ready));
  assign bus.req_ready    = rst_n ? w_ready : '0;
  assign bus.fifo_wr_en   = w_wr_en;
  assign bus.fifo_din     = w_wr_en ? bus.req_data[w_gnt_id*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign bus.grant_id     = w_wr_en ? w_gnt_id : '0;
  assign bus.burst_active = rst_n && (r_state == BURST);
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares the single write port of the team's synchronous FIFO between `NUM_REQ` producers. Each producer presents data with a valid/ready handshake. The arbiter grants one producer at a time for bursts of up to `MAX_BURST` beats and drives the FIFO's `wr_en`/`din`. It observes FIFO `full` so that no beat is ever offered to a full FIFO and no beat is ever lost.

## Interface
- `NUM_REQ`, default 4: number of producers (≥2).
- `DATA_WIDTH`, default 8: beat width; equals the FIFO's data width.
- `MAX_BURST`, default 4: maximum consecutive beats granted to one producer (≥1).
- `IDW` (local): $clog2(`NUM_REQ`).
- `CW` (local): $clog2(`MAX_BURST`+1).

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `req_valid`  in  `NUM_REQ`: bit i means producer i offers a beat.
- `req_data`  in  `NUM_REQ`*`DATA_WIDTH`: producer i data in slice [i*`DATA_WIDTH` +: `DATA_WIDTH`].
- `req_ready`  out  `NUM_REQ`: one-hot or zero; beat i transfers when `req_valid`[i] & `req_ready`[i].
- `fifo_full`  in  1: FIFO full flag.
- `fifo_wr_en`  out  1: write strobe to the FIFO.
- `fifo_din`  out  `DATA_WIDTH`: data to the FIFO.
- `grant_id`  out  `IDW`: index of the producer writing this cycle; meaningful only when `fifo_wr_en`=1.
- `burst_active`  out  1: high while in the BURST state.

## Operation
Internal registers:
- `state` ∈ {IDLE, BURST}.
- `owner` (`IDW` bits).
- `last`: round-robin pointer (`IDW` bits).
- `burst_cnt` (`CW` bits).

Reset values: `state`=IDLE, `owner`=0, `last`=`NUM_REQ`-1, `burst_cnt`=0. This makes producer 0 win first.

Output rules:
- `req_ready`, `fifo_wr_en`, `fifo_din` and `grant_id` are combinational from state and inputs.
- While `rst_n`=0, all outputs are forced to 0.
- `fifo_wr_en` = OR of (`req_valid` & `req_ready`). `fifo_din` = `req_data` slice of the granted producer, else 0.
- `req_ready` is never asserted while `fifo_full`=1.

IDLE:
- `sel` = first i with `req_valid`[i]=1, scanning circularly from `last`+1 (mod `NUM_REQ`).
- No valid requester, or `fifo_full`=1: no grant; registers hold. There is no reservation; the next cycle re-arbitrates.
- Otherwise: `req_ready`[`sel`]=1 and the beat transfers this cycle. Update `owner`←`sel`, `last`←`sel`, `burst_cnt`←1. Go to BURST if `MAX_BURST`>1, else stay in IDLE.

BURST (only `owner` may be granted):
- `req_valid`[`owner`]=1 and `fifo_full`=0: transfer. Then `burst_cnt`←`burst_cnt`+1. If the new count equals `MAX_BURST`: `state`←IDLE and `burst_cnt`←0.
- `req_valid`[`owner`]=1 and `fifo_full`=1: stall. No ready, all registers hold, the burst resumes when full clears.
- `req_valid`[`owner`]=0: release. No transfer this cycle, `state`←IDLE, `burst_cnt`←0. This costs one bubble cycle.
- Valid bits of other producers are ignored in BURST.

Producers must hold `req_valid` and `req_data` stable until transfer; the arbiter does not check this. Round-robin plus `MAX_BURST` guarantees that a continuously valid producer is granted within (`NUM_REQ`-1)*`MAX_BURST` beats plus stall cycles.

## Timing
- Zero-latency handshake: data transfers to the FIFO in the same cycle that `req_ready` is high.
- Accepted-beat throughput: 1 per cycle while the FIFO is not full and the owner stays valid. A burst ending at `MAX_BURST` is followed directly by an IDLE-state grant in the next cycle, with no bubble.
- Owner releasing early: exactly 1 bubble cycle.
- `fifo_full` acts in the same cycle: a cycle with `fifo_full`=1 never has `fifo_wr_en`=1.
- Synchronous reset asserted mid-burst: the burst is abandoned at the next edge and registers return to reset values. The FIFO receives no partial writes because writes are single-cycle beats.
- `burst_active` is registered-state derived: it is 1 in every cycle where `state`=BURST.

## Test plan
- Only `req_valid`[0]=1, continuous, `MAX_BURST`=4, FIFO never full: `fifo_wr_en`=1 every cycle, `grant_id`=0 every cycle, `burst_active` pattern 0,1,1,1 repeating.
- All four valid with distinct data: `grant_id` sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0… and `fifo_din` matches the granted slice each beat.
- `fifo_full`=1 for 3 cycles after beat 2 of producer 1's burst: `req_ready`=0 and `fifo_wr_en`=0 for those cycles, `burst_cnt` holds at 2; beats 3 and 4 then complete for producer 1.
- Producer 2 drops valid after 2 beats while producers 3 and 0 are valid: 1 bubble cycle, then producer 3 is granted for 4 beats.
- `rst_n`=0 for one cycle mid-burst of producer 2: all outputs 0 during reset, `burst_active`=0 after; the next grant with all valid goes to producer 0.
- `MAX_BURST`=1 with producers 0 and 1 valid: grants strictly alternate 0,1,0,1 and `burst_active` stays 0.
